// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared layer geometry, pixel format and blitter state encoding
// Contents:
//   DEPTH/DATA_WIDTH/LWIDTH/LHEIGHT/AWIDTH/XWIDTH/YWIDTH : layer store geometry
//   pixel_t      : packed {r,g,b,a} VRAM word layout
//   pack_pixel   : struct -> VRAM word
//   unpack_pixel : VRAM word -> struct, for the display read path
//   blit_state_e : write-side blitter FSM states
package layer_pkg;

  localparam int DEPTH      = 4;
  localparam int DATA_WIDTH = 3 * DEPTH + 1;
  localparam int LWIDTH     = 160;
  localparam int LHEIGHT    = 120;
  localparam int AWIDTH     = 15;
  localparam int XWIDTH     = $clog2(LWIDTH);
  localparam int YWIDTH     = $clog2(LHEIGHT);

  typedef struct packed {
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] g;
    logic [DEPTH-1:0] b;
    logic             a;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } blit_state_e;

  function automatic logic [DATA_WIDTH-1:0] pack_pixel(input pixel_t p);
    return {p.r, p.g, p.b, p.a};
  endfunction

  function automatic pixel_t unpack_pixel(input logic [DATA_WIDTH-1:0] d);
    return pixel_t'(d);
  endfunction

endpackage

// File: rtl/rect_clip.sv
// rtl/rect_clip.sv - combinational rectangle clipping against the layer bounds
// Ports:
//   x0_i, y0_i    : rectangle top-left corner
//   w_i, h_i      : rectangle size in pixels
//   x_end_o       : exclusive right bound, min(x0+w, LWIDTH)
//   y_end_o       : exclusive bottom bound, min(y0+h, LHEIGHT)
//   empty_o       : nothing of the rectangle lies inside the layer
module rect_clip
  import layer_pkg::*;
(
  input  logic [XWIDTH-1:0] x0_i,
  input  logic [YWIDTH-1:0] y0_i,
  input  logic [XWIDTH:0]   w_i,
  input  logic [YWIDTH:0]   h_i,
  output logic [XWIDTH+1:0] x_end_o,
  output logic [YWIDTH+1:0] y_end_o,
  output logic              empty_o
);

  localparam logic [XWIDTH+1:0] X_LIM = (XWIDTH+2)'(LWIDTH);
  localparam logic [YWIDTH+1:0] Y_LIM = (YWIDTH+2)'(LHEIGHT);

  logic [XWIDTH+1:0] x_sum;
  logic [YWIDTH+1:0] y_sum;

  // Two extra bits hold the largest possible x0+w / y0+h without wrapping.
  always_comb begin
    x_sum   = {2'b00, x0_i} + {1'b0, w_i};
    y_sum   = {2'b00, y0_i} + {1'b0, h_i};
    x_end_o = (x_sum > X_LIM) ? X_LIM : x_sum;
    y_end_o = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    empty_o = (w_i == '0) || (h_i == '0) ||
              ({2'b00, x0_i} >= X_LIM) || ({2'b00, y0_i} >= Y_LIM);
  end

endmodule

// File: rtl/layer_blitter.sv
// rtl/layer_blitter.sv - fills a clipped rectangle of a layer VRAM with one colour
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : command strobe, only accepted while idle
//   x0_i, y0_i, w_i, h_i   : rectangle (left, top, width, height)
//   r_i, g_i, b_i, a_i     : fill colour
//   wr_allow_i             : arbiter grant for a VRAM write this cycle
//   busy_o, done_o         : command in progress / one-cycle completion pulse
//   we_o, waddr_o, wdata_o : VRAM write port
module layer_blitter
  import layer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [XWIDTH-1:0]     x0_i,
  input  logic [YWIDTH-1:0]     y0_i,
  input  logic [XWIDTH:0]       w_i,
  input  logic [YWIDTH:0]       h_i,
  input  logic [DEPTH-1:0]      r_i,
  input  logic [DEPTH-1:0]      g_i,
  input  logic [DEPTH-1:0]      b_i,
  input  logic                  a_i,
  input  logic                  wr_allow_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  we_o,
  output logic [AWIDTH-1:0]     waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o
);

  localparam logic [AWIDTH-1:0] ROW_STEP = AWIDTH'(LWIDTH);

  blit_state_e           state_q, state_d;
  logic [XWIDTH-1:0]     x0_q, x0_d;
  logic [YWIDTH-1:0]     y0_q, y0_d;
  logic [XWIDTH:0]       w_q, w_d;
  logic [YWIDTH:0]       h_q, h_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic [XWIDTH+1:0]     x_end_q, x_end_d;
  logic [YWIDTH+1:0]     y_end_q, y_end_d;
  logic [XWIDTH-1:0]     x_cnt_q, x_cnt_d;
  logic [YWIDTH-1:0]     y_cnt_q, y_cnt_d;
  logic [AWIDTH-1:0]     row_base_q, row_base_d;

  logic [XWIDTH+1:0]     clip_x_end;
  logic [YWIDTH+1:0]     clip_y_end;
  logic                  clip_empty;
  logic                  x_at_end;
  logic                  y_at_end;
  logic                  we_c;
  pixel_t                pix_in;

  assign pix_in = '{r: r_i, g: g_i, b: b_i, a: a_i};

  // Clipping works from the latched command so it is stable through SETUP.
  rect_clip u_rect_clip (
    .x0_i    (x0_q),
    .y0_i    (y0_q),
    .w_i     (w_q),
    .h_i     (h_q),
    .x_end_o (clip_x_end),
    .y_end_o (clip_y_end),
    .empty_o (clip_empty)
  );

  // x_end/y_end are exclusive and at least x0+1/y0+1 once in FILL.
  assign x_at_end = ({2'b00, x_cnt_q} == (x_end_q - (XWIDTH+2)'(1)));
  assign y_at_end = ({2'b00, y_cnt_q} == (y_end_q - (YWIDTH+2)'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      pix_q      <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      pix_q      <= pix_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      row_base_q <= row_base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    pix_d      = pix_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    row_base_d = row_base_q;
    we_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          x0_d    = x0_i;
          y0_d    = y0_i;
          w_d     = w_i;
          h_d     = h_i;
          pix_d   = pack_pixel(pix_in);
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        x_end_d    = clip_x_end;
        y_end_d    = clip_y_end;
        row_base_d = AWIDTH'(y0_q) * ROW_STEP;
        x_cnt_d    = x0_q;
        y_cnt_d    = y0_q;
        state_d    = clip_empty ? ST_DONE : ST_FILL;
      end

      ST_FILL: begin
        // A denied cycle leaves every counter untouched, so the same
        // pixel is presented again on the next granted cycle.
        we_c = wr_allow_i;
        if (wr_allow_i) begin
          if (x_at_end) begin
            if (y_at_end) begin
              state_d = ST_DONE;
            end else begin
              x_cnt_d    = x0_q;
              y_cnt_d    = y_cnt_q + YWIDTH'(1);
              row_base_d = row_base_q + ROW_STEP;
            end
          end else begin
            x_cnt_d = x_cnt_q + XWIDTH'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign we_o    = we_c;
  assign waddr_o = (state_q == ST_FILL) ? (row_base_q + AWIDTH'(x_cnt_q)) : '0;
  assign wdata_o = (state_q == ST_FILL) ? pix_q : '0;

endmodule
